div_unit: RTL and testbench

//  Iterative 32-bit signed/unsigned divider for DIV/DIVU in the EX stage, fed by the same

---
 rtl/div_unit.sv | 217 +++++++++++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// -----------------------------------------------------------------------------
// Iterative signed/unsigned divider for DIV/DIVU in the EX stage. It uses a
// radix-2 restoring algorithm and produces one quotient bit per clock. The
// pipeline is held through the stall output while a divide is in flight. The
// finished {remainder, quotient} pair is presented for one cycle with ready so
// that HI/LO can be written (HI = remainder, LO = quotient).
//
// Ports
//   clk         in   1        single clock, rising edge
//   rst         in   1        synchronous reset, active-high
//   start       in   1        divide request (decoded DIV/DIVU in EX)
//   signed_div  in   1        1 = DIV (signed), 0 = DIVU; sampled with start
//   annul       in   1        cancel an in-flight divide (EX flush / exception)
//   a           in   WIDTH    dividend (rs)
//   b           in   WIDTH    divisor (rt)
//   stall       out  1        hold IF/ID/EX while a divide is in progress
//   ready       out  1        one-cycle pulse: result valid, write HI/LO
//   result      out  2*WIDTH  {remainder, quotient}; held until next completion
//
// Timing (start accepted in cycle 0)
//   b != 0 : CALC for WIDTH cycles, ready in cycle WIDTH+1
//   b == 0 : ZERO for one cycle,   ready in cycle 2
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 stall,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Negate v when en is set, otherwise pass it through.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = neg_val(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Magnitude of an operand; only negative values in signed mode change.
    // The most negative value maps onto itself, which is still the correct
    // unsigned magnitude (2^(WIDTH-1)).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
        return cond_neg(v, is_signed & v[WIDTH-1]);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_rem;       // partial remainder
    logic [WIDTH-1:0]   r_quo;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_divisor;   // |b|
    logic [WIDTH-1:0]   r_dividend;  // original a, returned as remainder on divide-by-zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_result;

    // -------------------------------------------------------------------------
    // One restoring iteration
    // -------------------------------------------------------------------------
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_trial;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_rem_final;
    logic [WIDTH-1:0]   w_quo_final;
    logic               w_last;
    logic               w_b_zero;

    // Shift {rem,quo} left, trial-subtract the divisor, keep or restore.
    always_comb begin
        w_shifted = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, r_divisor};
        // The shifted remainder is always below 2*divisor and the divisor is
        // below 2^WIDTH, so bit WIDTH of the difference is set exactly when
        // the subtraction borrowed.
        w_borrow  = w_trial[WIDTH];
        if (w_borrow) begin
            w_rem_next = w_shifted[WIDTH-1:0];
        end else begin
            w_rem_next = w_trial[WIDTH-1:0];
        end
        w_quo_next  = {r_quo[WIDTH-2:0], ~w_borrow};
        w_rem_final = cond_neg(w_rem_next, r_neg_r);
        w_quo_final = cond_neg(w_quo_next, r_neg_q);
        w_last      = (r_count == LAST_ITER);
        w_b_zero    = (b == {WIDTH{1'b0}});
    end

    // Pipeline hold: asserted for the accepting cycle and every busy cycle.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            S_IDLE:  stall = start & ~annul;
            S_CALC:  stall = 1'b1;
            S_ZERO:  stall = 1'b1;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Divider control FSM with registered ready/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= {CW{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
            r_quo      <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_dividend <= {WIDTH{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ready    <= 1'b0;
            r_result   <= {(2*WIDTH){1'b0}};
        end else if (annul) begin
            // Drop whatever is in progress; the last result stays visible.
            r_state <= S_IDLE;
            r_count <= {CW{1'b0}};
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (start) begin
                        r_rem      <= {WIDTH{1'b0}};
                        r_quo      <= mag(a, signed_div);
                        r_divisor  <= mag(b, signed_div);
                        r_dividend <= a;
                        r_neg_q    <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r    <= signed_div & a[WIDTH-1];
                        r_count    <= {CW{1'b0}};
                        if (w_b_zero) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_ready <= 1'b0;
                    if (w_last) begin
                        // Sign correction is folded into the final write so
                        // the result lands on DONE entry with no extra cycle.
                        r_count  <= {CW{1'b0}};
                        r_result <= {w_rem_final, w_quo_final};
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                        r_state <= S_CALC;
                    end
                end
                S_ZERO: begin
                    // Defined divide-by-zero result: q = all ones, r = a.
                    r_result <= {r_dividend, {WIDTH{1'b1}}};
                    r_ready  <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    // start is not looked at here; a held start is picked up
                    // in the following IDLE cycle.
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .stall      (stall),
        .ready      (ready),
        .result     (result)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide in the current cycle (cycle 0) and follow it to ready.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s, input string tag);
        logic [63:0] exp_res;
        int lat, n, stall_cnt, ready_at;
        logic stall_at_ready;
        exp_res = model(x, y, s);
        lat = (y == 32'd0) ? 2 : 33;
        a = x; b = y; signed_div = s; start = 1'b1; annul = 1'b0;
        #1;
        stall_cnt = stall ? 1 : 0;
        ready_at = -1;
        stall_at_ready = 1'b1;
        n = 0;
        while (ready_at < 0 && n < 60) begin
            tick();
            n++;
            if (ready) begin
                ready_at = n;
                stall_at_ready = stall;
                check_val({tag, "_result"}, result, exp_res);
            end else if (stall) begin
                stall_cnt++;
            end
            if (n == 1) begin
                // Operands after the start cycle must not matter.
                start = 1'b0;
                a = $urandom;
                b = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
        end
        check_val({tag, "_latency"}, 64'(ready_at), 64'(lat));
        check_val({tag, "_stall_at_ready"}, 64'(stall_at_ready), 64'd0);
        check_val({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
        tick();
        check_val({tag, "_ready_pulse"}, 64'(ready), 64'd0);
        check_val({tag, "_held"}, result, exp_res);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] exp1, exp2;
        int r1_at, r2_at;

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        check_val("reset_ready", 64'(ready), 64'd0);
        check_val("reset_result", result, 64'd0);
        check_val("reset_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        run_div(32'hFFFF_FFFF, 32'h10, 1'b0, "divu_big");
        run_div(32'h1234, 32'd0, 1'b0, "divu_zero");
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, "div_zero_neg");
        run_div(32'd7, 32'd2, 1'b0, "divu_7_2");

        // Annul at cycle 10: no ready, result kept, stall drops at cycle 11
        a = 32'd100; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        seen = 0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (ready) seen++;
            if (n == 10) annul = 1'b1;
            if (n == 11) annul = 1'b0;
        end
        check_val("annul_no_ready", 64'(seen), 64'd0);
        check_val("annul_result_kept", result, {32'd1, 32'd3});
        check_val("annul_stall_low", 64'(stall), 64'd0);
        tick();
        run_div(32'd100, 32'd3, 1'b0, "after_annul");

        // Reset at cycle 15 of a divide
        a = 32'd1000; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (n == 15) rst = 1'b1;
        end
        check_val("rst_mid_ready", 64'(ready), 64'd0);
        check_val("rst_mid_stall", 64'(stall), 64'd0);
        check_val("rst_mid_result", result, 64'd0);
        rst = 1'b0;
        tick();

        // annul together with start in IDLE drops the request; no ready
        // appears without an accepted start.
        a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
        #1;
        check_val("annul_start_stall", 64'(stall), 64'd0);
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                annul = 1'b0;
            end
            a = $urandom;
            b = $urandom;
            if (ready) seen++;
        end
        check_val("dropped_no_ready", 64'(seen), 64'd0);
        check_val("dropped_stall", 64'(stall), 64'd0);
        check_val("dropped_result", result, 64'd0);

        // Back-to-back: start held through DONE
        exp1 = model(32'd91, 32'd4, 1'b0);
        exp2 = model(32'hFFFF_FF00, 32'd9, 1'b1);
        a = 32'd91; b = 32'd4; signed_div = 1'b0; start = 1'b1;
        seen = 0; r1_at = -1; r2_at = -1;
        for (int n = 1; n <= 75; n++) begin
            tick();
            if (ready) begin
                seen++;
                if (r1_at < 0) begin
                    r1_at = n;
                    check_val("b2b_first_result", result, exp1);
                end else begin
                    r2_at = n;
                    check_val("b2b_second_result", result, exp2);
                end
            end
            if (n == 33) begin
                a = 32'hFFFF_FF00; b = 32'd9; signed_div = 1'b1;
            end
            if (n == 35) start = 1'b0;
        end
        check_val("b2b_first_at", 64'(r1_at), 64'd33);
        check_val("b2b_second_at", 64'(r2_at), 64'd67);
        check_val("b2b_pulses", 64'(seen), 64'd2);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = $urandom;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: begin ra = 32'($urandom_range(0, 100)); rb = $urandom; end
            endcase
            run_div(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
